// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// Requester ids are sized for the largest supported requester count.
package sram_arb_pkg;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 16;
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational rotating-priority picker.
// Scans upward from ptr+1 with an explicit wrap, or honours the lock holder.
module sram_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            ptr,
  input  logic               lock,
  input  req_id_t            holder,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = int'(ptr);
    if (lock) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (int'(holder) == j) begin
          grant[j] = req[j];
          idx      = req_id_t'(j);
        end
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (cand >= NUM_REQ - 1) ? 0 : cand + 1;
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!found && j == cand && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = req_id_t'(j);
          end
        end
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one external SRAM port among NUM_REQ requesters,
// with exclusive-burst locking and in-order read data return.
module sram_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16
) (
  input  logic                           Clock,
  input  logic                           Resetn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we_n,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_address,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_write_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             rd_valid,
  output logic [DATA_W-1:0]              rd_data,
  output logic [ADDR_W-1:0]              SRAM_address,
  output logic [DATA_W-1:0]              SRAM_write_data,
  output logic                           SRAM_we_n,
  input  logic [DATA_W-1:0]              SRAM_read_data
);

  import sram_arb_pkg::*;

  req_id_t             ptr_reg, holder_reg, pick_idx;
  logic                lock_reg;
  rd_tag_t             pipe_reg [READ_LATENCY];
  logic                accept, holder_req, sel_we_n, sel_lock;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NUM_REQ-1:0]  ret_onehot;

  sram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .lock   (lock_reg),
    .holder (holder_reg),
    .grant  (grant),
    .idx    (pick_idx)
  );

  assign accept = |grant;

  // grant is one-hot, so an OR-mux selects the winner's fields
  always_comb begin
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_we_n   = 1'b1;
    sel_lock   = 1'b0;
    holder_req = 1'b0;
    ret_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_addr  = req_address[k];
        sel_wdata = req_write_data[k];
        sel_we_n  = req_we_n[k];
        sel_lock  = req_lock[k];
      end
      if (int'(holder_reg) == k) holder_req = req[k];
      if (pipe_reg[READ_LATENCY-1].valid && int'(pipe_reg[READ_LATENCY-1].id) == k)
        ret_onehot[k] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      ptr_reg         <= req_id_t'(NUM_REQ - 1);
    end else if (accept) begin
      SRAM_address    <= sel_addr;
      SRAM_write_data <= sel_wdata;
      SRAM_we_n       <= sel_we_n;
      ptr_reg         <= pick_idx;
    end else begin
      SRAM_we_n       <= 1'b1;
    end
  end

  // While locked only the holder can be accepted, so sel_lock is the holder's.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lock_reg   <= 1'b0;
      holder_reg <= '0;
    end else if (lock_reg) begin
      if (!holder_req || (accept && !sel_lock)) lock_reg <= 1'b0;
    end else if (accept && sel_lock) begin
      lock_reg   <= 1'b1;
      holder_reg <= pick_idx;
    end
  end

  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
          pipe_reg[gi] <= '0;
        end else if (gi == 0) begin
          pipe_reg[gi] <= '{valid: accept & sel_we_n, id: pick_idx};
        end else begin
          pipe_reg[gi] <= pipe_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= ret_onehot;
      if (pipe_reg[READ_LATENCY-1].valid) rd_data <= SRAM_read_data;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed stimulus pushes expected grants,
// bus values and read returns; a negedge monitor pops and compares.
module tb_sram_arbiter;

  localparam int N  = 3;
  localparam int AW = 18;
  localparam int DW = 16;

  logic                   Clock = 1'b0;
  logic                   Resetn = 1'b0;
  logic [N-1:0]           req = '0, req_we_n = '1, req_lock = '0;
  logic [N-1:0][AW-1:0]   req_address = '0;
  logic [N-1:0][DW-1:0]   req_write_data = '0;
  logic [N-1:0]           grant, rd_valid;
  logic [DW-1:0]          rd_data, SRAM_write_data;
  logic [AW-1:0]          SRAM_address;
  logic                   SRAM_we_n;
  logic [DW-1:0]          sram_rd = '0;

  always #5 Clock = ~Clock;

  sram_arbiter #(.NUM_REQ(N), .READ_LATENCY(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .req            (req),
    .req_we_n       (req_we_n),
    .req_lock       (req_lock),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .grant          (grant),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .SRAM_read_data (sram_rd)
  );

  // SRAM model: two-edge read latency from address registration to sampling
  logic [DW-1:0] mem [0:1023];
  bit            plus1 = 1'b0;
  always @(posedge Clock) begin
    if (!SRAM_we_n) mem[SRAM_address[9:0]] <= SRAM_write_data;
    sram_rd <= plus1 ? DW'(SRAM_address + 18'd1) : mem[SRAM_address[9:0]];
  end

  typedef struct {
    logic [N-1:0]  grant;
    bit            chk_bus;
    logic          we_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gtxn_t;

  typedef struct {
    logic [N-1:0]  id;
    logic [DW-1:0] data;
    int            due;
  } rtxn_t;

  gtxn_t gq[$];
  rtxn_t rq[$];
  int    n_tests = 0, n_fail = 0, cyc = 0, we_low = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor
  bit    bus_pend = 1'b0;
  gtxn_t bus_exp, g;
  rtxn_t r;
  always @(negedge Clock) begin
    if (!SRAM_we_n) we_low++;
    if (bus_pend) begin
      bus_pend = 1'b0;
      chk("bus_we_n", 32'(SRAM_we_n), 32'(bus_exp.we_n));
      if (bus_exp.grant != '0) begin
        chk("bus_addr", 32'(SRAM_address), 32'(bus_exp.addr));
        chk("bus_wdata", 32'(SRAM_write_data), 32'(bus_exp.wdata));
      end
    end
    if (gq.size() > 0) begin
      g = gq.pop_front();
      chk("grant", 32'(grant), 32'(g.grant));
      $display("[TB] cycle %0d grant=%b exp=%b", cyc, grant, g.grant);
      if (g.chk_bus) begin
        bus_pend = 1'b1;
        bus_exp  = g;
      end
    end
    if (rd_valid != '0) begin
      if (rq.size() == 0) begin
        chk("rd_unexpected", 32'(rd_valid), 32'(0));
      end else begin
        r = rq.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'(r.id));
        chk("rd_data", 32'(rd_data), 32'(r.data));
        chk("rd_latency", 32'(cyc), 32'(r.due));
        $display("[TB] cycle %0d read return id=%b data=%h", cyc, rd_valid, rd_data);
      end
    end
  end

  // Called at posedge+1 with inputs already set for this cycle.
  task automatic step(input logic [N-1:0] eg, input bit cb, input bit er, input logic [DW-1:0] ed);
    gtxn_t t;
    t.grant = eg; t.chk_bus = cb; t.we_n = 1'b1; t.addr = '0; t.wdata = '0;
    for (int k = 0; k < N; k++) begin
      if (eg[k]) begin
        t.we_n  = req_we_n[k];
        t.addr  = req_address[k];
        t.wdata = req_write_data[k];
      end
    end
    gq.push_back(t);
    if (er) rq.push_back('{id: eg, data: ed, due: cyc + 3});
    @(posedge Clock); #1;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    req = '0; req_lock = '0; req_we_n = '1;
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_we_n", 32'(SRAM_we_n), 32'(1));
    chk("rst_addr", 32'(SRAM_address), 32'(0));
    chk("rst_wdata", 32'(SRAM_write_data), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));

    // single requester write then read
    we_low = 0;
    req = 3'b001; req_we_n = 3'b110; req_address[0] = 18'h00010; req_write_data[0] = 16'hA5A5;
    step(3'b001, 1, 0, 16'h0);
    req_we_n = 3'b111; req_write_data[0] = 16'h0000;
    step(3'b001, 1, 1, 16'hA5A5);
    req = '0;
    repeat (5) step(3'b000, 1, 0, 16'h0);
    chk("we_low_once", 32'(we_low), 32'(1));

    // contention rotation
    do_reset();
    req = 3'b111; req_we_n = 3'b000;
    for (int k = 0; k < N; k++) begin
      req_address[k]    = AW'(18'h100 + k);
      req_write_data[k] = DW'(16'h1000 + k);
    end
    step(3'b001, 1, 0, 0); step(3'b010, 1, 0, 0); step(3'b100, 1, 0, 0);
    step(3'b001, 1, 0, 0); step(3'b010, 1, 0, 0); step(3'b100, 1, 0, 0);
    req = '0;
    step(3'b000, 1, 0, 0);

    // lock burst by requester 1
    do_reset();
    req_we_n = 3'b000;
    req = 3'b010; req_lock = 3'b010;
    step(3'b010, 1, 0, 0);
    req = 3'b111;
    step(3'b010, 1, 0, 0);
    step(3'b010, 1, 0, 0);
    req_lock = 3'b000;
    step(3'b010, 1, 0, 0);
    req = 3'b101;
    step(3'b100, 1, 0, 0);
    step(3'b001, 1, 0, 0);
    req = '0;
    step(3'b000, 1, 0, 0);

    // lock released by holder dropping req
    do_reset();
    req_we_n = 3'b000;
    req = 3'b100; req_lock = 3'b100;
    step(3'b100, 1, 0, 0);
    req = 3'b011; req_lock = 3'b000;
    step(3'b000, 1, 0, 0);
    step(3'b001, 1, 0, 0);
    req = '0;
    step(3'b000, 1, 0, 0);

    // pipelined reads, model returns address+1
    do_reset();
    plus1 = 1'b1;
    req = 3'b001; req_we_n = 3'b111;
    for (int i = 0; i < 8; i++) begin
      req_address[0] = AW'(i);
      step(3'b001, 1, 1, DW'(i + 1));
    end
    req = '0;
    repeat (5) step(3'b000, 1, 0, 0);
    plus1 = 1'b0;

    // reset with reads in flight and a write on the bus
    do_reset();
    req = 3'b001; req_we_n = 3'b111; req_address[0] = 18'h0;
    step(3'b001, 1, 0, 0);
    req_address[0] = 18'h1;
    step(3'b001, 1, 0, 0);
    req = 3'b010; req_we_n = 3'b101; req_address[1] = 18'h20; req_write_data[1] = 16'h5A5A;
    step(3'b010, 0, 0, 0);
    chk("pre_rst_rd_valid", 32'(rd_valid), 32'(3'b001));
    chk("pre_rst_we_n", 32'(SRAM_we_n), 32'(0));
    #1 Resetn = 1'b0;
    #1;
    chk("midrst_we_n", 32'(SRAM_we_n), 32'(1));
    chk("midrst_rd_valid", 32'(rd_valid), 32'(0));
    req = '0; req_we_n = '1;
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
    repeat (6) step(3'b000, 1, 0, 0);
    req = 3'b111; req_we_n = 3'b000;
    step(3'b001, 1, 0, 0);
    req = '0;
    repeat (3) step(3'b000, 1, 0, 0);

    @(negedge Clock); #1;
    chk("rq_drained", 32'(rq.size()), 32'(0));
    chk("gq_drained", 32'(gq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
